// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: parity mode encodings,
// the transmitter state encoding, the width of the run-time baud divisor
// and a clogb2 helper used to size counters.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int BAUD_DIV_W = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_DATA    = 3'd3,
        ST_PARITY  = 3'd4,
        ST_STOP    = 3'd5,
        ST_BRK     = 3'd6,
        ST_BRK_REL = 3'd7
    } state_t;

    // Number of bits needed to hold the value (clogb2(65535) = 16).
    function automatic int clogb2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >>> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period timer. Counts 0..D-1 and pulses bitEnd_o on count D-1, then
// wraps. restart_i holds the count at zero so the first bit of a frame
// starts from a clean period.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   div_i      bit period D in clocks (always >= 2 when used)
//   restart_i  hold counter at zero
//   bitEnd_o   high on the last clock of a bit period
//   preEnd_o   high on the clock before the last clock of a bit period
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BAUD_DIV_W-1:0] div_i,
    input  logic                  restart_i,
    output logic                  bitEnd_o,
    output logic                  preEnd_o
);

    localparam int CNT_W = clogb2(65535);

    logic [CNT_W-1:0] cnt_q;

    // The counter wraps on its own terminal count so consecutive bits are
    // back to back with no dead clock between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart_i || bitEnd_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // preEnd lets the owner register a pulse that lines up with bitEnd.
    assign bitEnd_o = (cnt_q == CNT_W'(div_i - BAUD_DIV_W'(1)));
    assign preEnd_o = (cnt_q == CNT_W'(div_i - BAUD_DIV_W'(2)));

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Parametrised RS-232 transmitter. Pulls one word per frame from a
// non-show-ahead FIFO and sends start, data (LSB first), optional parity and
// stop bits. Also generates line breaks on request.
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   tx             serial line, idle high, registered
//   tx_fifo_data   word from the FIFO, valid P_FIFO_LATENCY clocks after read
//   tx_fifo_rd_en  one-cycle FIFO read strobe
//   tx_fifo_empty  FIFO empty flag (only looked at in IDLE)
//   baud_div       run-time bit period; 0 = default, 1 is treated as 2
//   tx_break       hold the line low while high
//   busy           high whenever the FSM is not IDLE
//   tx_done        pulse on the last clock of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int P_CLK_FREQ_HZ  = 100000000,
    parameter int P_BAUD_RATE    = 9600,
    parameter int P_DATA_BITS    = 8,
    parameter int P_PARITY       = 0,
    parameter int P_STOP_BITS    = 1,
    parameter int P_FIFO_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   tx,
    input  logic [P_DATA_BITS-1:0] tx_fifo_data,
    output logic                   tx_fifo_rd_en,
    input  logic                   tx_fifo_empty,
    input  logic [BAUD_DIV_W-1:0]  baud_div,
    input  logic                   tx_break,
    output logic                   busy,
    output logic                   tx_done
);

    localparam int D0 = P_CLK_FREQ_HZ / P_BAUD_RATE;
    localparam logic [BAUD_DIV_W-1:0] D0_W      = BAUD_DIV_W'(D0);
    localparam logic [1:0]            LOAD_LAST = 2'(P_FIFO_LATENCY);
    localparam logic [3:0]            DATA_LAST = 4'(P_DATA_BITS - 1);
    localparam logic [3:0]            STOP_LAST = 4'(P_STOP_BITS - 1);

    if (P_DATA_BITS < 5 || P_DATA_BITS > 9) begin : gBadDataBits
        $error("uart_tx_frame: P_DATA_BITS must be 5..9");
    end
    if (P_PARITY != PAR_NONE && P_PARITY != PAR_EVEN && P_PARITY != PAR_ODD) begin : gBadParity
        $error("uart_tx_frame: P_PARITY must be 0, 1 or 2");
    end
    if (P_STOP_BITS < 1 || P_STOP_BITS > 2) begin : gBadStopBits
        $error("uart_tx_frame: P_STOP_BITS must be 1 or 2");
    end
    if (P_FIFO_LATENCY < 1 || P_FIFO_LATENCY > 3) begin : gBadLatency
        $error("uart_tx_frame: P_FIFO_LATENCY must be 1..3");
    end
    if (D0 < 2 || D0 > 65535) begin : gBadDefaultDiv
        $error("uart_tx_frame: default bit period out of range");
    end

    state_t                  state_q;
    logic                    txReg_q;
    logic                    rdEn_q;
    logic                    done_q;
    logic [BAUD_DIV_W-1:0]   div_q;
    logic [BAUD_DIV_W-1:0]   div_d;
    logic [P_DATA_BITS-1:0]  shiftReg_q;
    logic                    parity_q;
    logic [3:0]              bitIdx_q;
    logic [1:0]              loadCnt_q;
    logic                    restart;
    logic                    bitEnd;
    logic                    preEnd;

    // Bit period selected for the next frame: zero picks the default, and
    // one is bumped to two so the timer always has a real terminal count.
    always_comb begin
        div_d = baud_div;
        if (baud_div == '0) begin
            div_d = D0_W;
        end else if (baud_div == BAUD_DIV_W'(1)) begin
            div_d = BAUD_DIV_W'(2);
        end
    end

    // The timer only runs in states that are measured in bit periods.
    assign restart = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_BRK);

    uart_baud_tick u_baud_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_i     (div_q),
        .restart_i (restart),
        .bitEnd_o  (bitEnd),
        .preEnd_o  (preEnd)
    );

    // Main transmit FSM. tx, the read strobe and the done pulse are all
    // registered here. The divisor is sampled only when leaving IDLE, so a
    // baud_div change never disturbs a frame or break already in progress.
    // The data word is sampled exactly when the FIFO presents it, one clock
    // after the latency counter expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            txReg_q    <= 1'b1;
            rdEn_q     <= 1'b0;
            done_q     <= 1'b0;
            div_q      <= '0;
            shiftReg_q <= '0;
            parity_q   <= 1'b0;
            bitIdx_q   <= '0;
            loadCnt_q  <= '0;
        end else begin
            rdEn_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    txReg_q   <= 1'b1;
                    bitIdx_q  <= '0;
                    loadCnt_q <= '0;
                    if (tx_break) begin
                        div_q   <= div_d;
                        txReg_q <= 1'b0;
                        state_q <= ST_BRK;
                    end else if (!tx_fifo_empty) begin
                        div_q   <= div_d;
                        rdEn_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (loadCnt_q == LOAD_LAST) begin
                        shiftReg_q <= tx_fifo_data;
                        parity_q   <= (P_PARITY == PAR_ODD) ? ~(^tx_fifo_data) : (^tx_fifo_data);
                        txReg_q    <= 1'b0;
                        state_q    <= ST_START;
                    end else begin
                        loadCnt_q <= loadCnt_q + 2'd1;
                    end
                end
                ST_START: begin
                    if (bitEnd) begin
                        txReg_q    <= shiftReg_q[0];
                        shiftReg_q <= shiftReg_q >> 1;
                        bitIdx_q   <= '0;
                        state_q    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bitEnd) begin
                        if (bitIdx_q == DATA_LAST) begin
                            bitIdx_q <= '0;
                            if (P_PARITY != PAR_NONE) begin
                                txReg_q <= parity_q;
                                state_q <= ST_PARITY;
                            end else begin
                                txReg_q <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            txReg_q    <= shiftReg_q[0];
                            shiftReg_q <= shiftReg_q >> 1;
                            bitIdx_q   <= bitIdx_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bitEnd) begin
                        txReg_q  <= 1'b1;
                        bitIdx_q <= '0;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bitIdx_q == STOP_LAST && preEnd) begin
                        done_q <= 1'b1;
                    end
                    if (bitEnd) begin
                        if (bitIdx_q == STOP_LAST) begin
                            state_q <= ST_IDLE;
                        end else begin
                            bitIdx_q <= bitIdx_q + 4'd1;
                        end
                    end
                end
                ST_BRK: begin
                    if (!tx_break) begin
                        txReg_q  <= 1'b1;
                        bitIdx_q <= '0;
                        state_q  <= ST_BRK_REL;
                    end
                end
                ST_BRK_REL: begin
                    if (bitEnd) begin
                        if (bitIdx_q == 4'd1) begin
                            state_q <= ST_IDLE;
                        end else begin
                            bitIdx_q <= bitIdx_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx            = txReg_q;
    assign tx_fifo_rd_en = rdEn_q;
    assign tx_done       = done_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed bench for uart_tx_frame. Three instances cover the parameter
// corners: A = 8N1 latency 1, B = 9 data bits even parity 2 stop latency 3,
// C = 8 data bits odd parity 1 stop latency 2. Each instance is fed by a
// small FIFO model whose read data is valid for exactly one clock, so a
// capture at the wrong time picks up a junk value.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic rst_n;
    logic tbInit;

    always #5 clk = ~clk;

    int testsRun;
    int testsFailed;

    // ---------------- DUT A: 8N1, latency 1, D0 = 10 ----------------
    logic        txA, rdA, emptyA, breakA, busyA, doneA;
    logic [7:0]  dataA;
    logic [15:0] baudA;
    logic [7:0]  memA [0:7];
    logic [7:0]  pipeA;
    int          headA, tailA, rdCntA;

    uart_tx_frame #(
        .P_CLK_FREQ_HZ(1000000), .P_BAUD_RATE(100000), .P_DATA_BITS(8),
        .P_PARITY(0), .P_STOP_BITS(1), .P_FIFO_LATENCY(1)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .tx(txA), .tx_fifo_data(dataA),
        .tx_fifo_rd_en(rdA), .tx_fifo_empty(emptyA), .baud_div(baudA),
        .tx_break(breakA), .busy(busyA), .tx_done(doneA)
    );

    // FIFO model A: read data shows up one clock after the strobe.
    always @(posedge clk) begin
        if (tbInit) begin
            headA  <= 0;
            rdCntA <= 0;
            pipeA  <= 8'h33;
        end else begin
            pipeA <= rdA ? memA[headA % 8] : 8'h33;
            if (rdA) begin
                headA  <= headA + 1;
                rdCntA <= rdCntA + 1;
            end
        end
    end
    assign emptyA = (headA == tailA);
    assign dataA  = pipeA;

    // ---------------- DUT B: 9E2, latency 3 ----------------
    logic        txB, rdB, emptyB, breakB, busyB, doneB;
    logic [8:0]  dataB;
    logic [15:0] baudB;
    logic [8:0]  memB [0:7];
    logic [8:0]  pipeB [0:2];
    int          headB, tailB, rdCntB;

    uart_tx_frame #(
        .P_CLK_FREQ_HZ(1000000), .P_BAUD_RATE(100000), .P_DATA_BITS(9),
        .P_PARITY(1), .P_STOP_BITS(2), .P_FIFO_LATENCY(3)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .tx(txB), .tx_fifo_data(dataB),
        .tx_fifo_rd_en(rdB), .tx_fifo_empty(emptyB), .baud_div(baudB),
        .tx_break(breakB), .busy(busyB), .tx_done(doneB)
    );

    // FIFO model B: three-stage pipe, data valid for one clock only.
    always @(posedge clk) begin
        if (tbInit) begin
            headB    <= 0;
            rdCntB   <= 0;
            pipeB[0] <= 9'h133;
            pipeB[1] <= 9'h133;
            pipeB[2] <= 9'h133;
        end else begin
            pipeB[0] <= rdB ? memB[headB % 8] : 9'h133;
            pipeB[1] <= pipeB[0];
            pipeB[2] <= pipeB[1];
            if (rdB) begin
                headB  <= headB + 1;
                rdCntB <= rdCntB + 1;
            end
        end
    end
    assign emptyB = (headB == tailB);
    assign dataB  = pipeB[2];

    // ---------------- DUT C: 8O1, latency 2 ----------------
    logic        txC, rdC, emptyC, breakC, busyC, doneC;
    logic [7:0]  dataC;
    logic [15:0] baudC;
    logic [7:0]  memC [0:7];
    logic [7:0]  pipeC [0:1];
    int          headC, tailC, rdCntC;

    uart_tx_frame #(
        .P_CLK_FREQ_HZ(1000000), .P_BAUD_RATE(100000), .P_DATA_BITS(8),
        .P_PARITY(2), .P_STOP_BITS(1), .P_FIFO_LATENCY(2)
    ) dutC (
        .clk(clk), .rst_n(rst_n), .tx(txC), .tx_fifo_data(dataC),
        .tx_fifo_rd_en(rdC), .tx_fifo_empty(emptyC), .baud_div(baudC),
        .tx_break(breakC), .busy(busyC), .tx_done(doneC)
    );

    // FIFO model C: two-stage pipe, data valid for one clock only.
    always @(posedge clk) begin
        if (tbInit) begin
            headC    <= 0;
            rdCntC   <= 0;
            pipeC[0] <= 8'h33;
            pipeC[1] <= 8'h33;
        end else begin
            pipeC[0] <= rdC ? memC[headC % 8] : 8'h33;
            pipeC[1] <= pipeC[0];
            if (rdC) begin
                headC  <= headC + 1;
                rdCntC <= rdCntC + 1;
            end
        end
    end
    assign emptyC = (headC == tailC);
    assign dataC  = pipeC[1];

    // Selected instance view used by the shared frame checker.
    int   sel;
    logic txS, doneS, busyS;

    always_comb begin
        txS   = txA;
        doneS = doneA;
        busyS = busyA;
        case (sel)
            1: begin
                txS   = txB;
                doneS = doneB;
                busyS = busyB;
            end
            2: begin
                txS   = txC;
                doneS = doneC;
                busyS = busyC;
            end
            default: begin
            end
        endcase
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun = testsRun + 1;
        if (observed !== expected) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Push one word into the FIFO model of the chosen instance.
    task automatic applyStimulus(input int which, input logic [8:0] word);
        case (which)
            0: begin
                memA[tailA % 8] = word[7:0];
                tailA = tailA + 1;
            end
            1: begin
                memB[tailB % 8] = word;
                tailB = tailB + 1;
            end
            default: begin
                memC[tailC % 8] = word[7:0];
                tailC = tailC + 1;
            end
        endcase
    endtask

    // Count falling-edge samples from the push until tx goes low.
    task automatic waitStart(input string tag, input int expLat);
        int cnt;
        cnt = 0;
        while (txS !== 1'b0 && cnt < 200) begin
            @(negedge clk);
            cnt = cnt + 1;
        end
        checkOutput({tag, " start latency"}, cnt, expLat);
    endtask

    // Sample one whole frame, one sample per clock, starting at the current
    // sample if tx is already low. Each bit must be constant for d clocks
    // and match the hand-built expected bit sequence.
    task automatic captureFrame(input string tag, input logic [8:0] word, input int nData,
                                input int par, input int nStop, input int d);
        logic expBits [0:15];
        int   nBits;
        int   waitCnt;
        int   doneCnt;
        int   doneIdx;
        int   k;
        int   obs;
        logic p;
        logic sawLow;
        logic sawHigh;

        expBits[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < nData; i++) begin
            expBits[1 + i] = word[i];
            p = p ^ word[i];
        end
        nBits = 1 + nData;
        if (par != 0) begin
            expBits[nBits] = (par == 2) ? ~p : p;
            nBits = nBits + 1;
        end
        for (int s = 0; s < nStop; s++) begin
            expBits[nBits] = 1'b1;
            nBits = nBits + 1;
        end

        waitCnt = 0;
        while (txS !== 1'b0 && waitCnt < 3000) begin
            @(negedge clk);
            waitCnt = waitCnt + 1;
        end
        if (txS !== 1'b0) begin
            checkOutput({tag, " start seen"}, 0, 1);
            return;
        end
        checkOutput({tag, " busy in frame"}, int'(busyS), 1);

        doneCnt = 0;
        doneIdx = -1;
        k = 0;
        for (int b = 0; b < nBits; b++) begin
            sawLow  = 1'b0;
            sawHigh = 1'b0;
            for (int j = 0; j < d; j++) begin
                if (txS === 1'b1) sawHigh = 1'b1;
                else sawLow = 1'b1;
                if (doneS === 1'b1) begin
                    doneCnt = doneCnt + 1;
                    doneIdx = k;
                end
                k = k + 1;
                @(negedge clk);
            end
            obs = (sawHigh && !sawLow) ? 1 : ((sawLow && !sawHigh) ? 0 : 2);
            checkOutput($sformatf("%s bit%0d", tag, b), obs, int'(expBits[b]));
        end
        checkOutput({tag, " done count"}, doneCnt, 1);
        checkOutput({tag, " done index"}, doneIdx, nBits * d - 1);
        checkOutput({tag, " busy after"}, int'(busyS), 0);
    endtask

    // Hard stop in case the sequence below gets stuck somewhere unexpected.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0;
        int cnt;

        testsRun    = 0;
        testsFailed = 0;
        tbInit      = 1'b1;
        rst_n       = 1'b0;
        sel         = 0;
        tailA = 0; tailB = 0; tailC = 0;
        breakA = 1'b0; breakB = 1'b0; breakC = 1'b0;
        baudA = 16'd0; baudB = 16'd0; baudC = 16'd0;

        repeat (3) @(negedge clk);
        tbInit = 1'b0;

        // Reset values.
        checkOutput("reset txA", int'(txA), 1);
        checkOutput("reset rdA", int'(rdA), 0);
        checkOutput("reset busyA", int'(busyA), 0);
        checkOutput("reset doneA", int'(doneA), 0);
        checkOutput("reset txB", int'(txB), 1);
        checkOutput("reset txC", int'(txC), 1);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A: basic 8N1 frame, default divisor.
        $display("[TB] A: 0xA5 8N1");
        sel = 0;
        r0 = rdCntA;
        applyStimulus(0, 9'h0A5);
        waitStart("A5", 3);
        captureFrame("A5", 9'h0A5, 8, 0, 1, 10);
        checkOutput("A5 rd_en count", rdCntA - r0, 1);

        // A: back-to-back frames with the FIFO kept non-empty.
        $display("[TB] A: back-to-back 0x55, 0x0F");
        r0 = rdCntA;
        applyStimulus(0, 9'h055);
        applyStimulus(0, 9'h00F);
        captureFrame("b2b 55", 9'h055, 8, 0, 1, 10);
        cnt = 0;
        while (txA === 1'b1 && cnt < 100) begin
            cnt = cnt + 1;
            @(negedge clk);
        end
        checkOutput("b2b gap", cnt, 3);
        captureFrame("b2b 0F", 9'h00F, 8, 0, 1, 10);
        checkOutput("b2b rd_en count", rdCntA - r0, 2);

        // A: reset during data bit 3, then a clean frame.
        $display("[TB] A: reset mid-frame");
        r0 = rdCntA;
        applyStimulus(0, 9'h0A5);
        waitStart("rst A5", 3);
        repeat (43) @(negedge clk);
        checkOutput("pre-reset bit3", int'(txA), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset tx", int'(txA), 1);
        checkOutput("async reset busy", int'(busyA), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(0, 9'h03C);
        waitStart("post-rst 3C", 3);
        captureFrame("post-rst 3C", 9'h03C, 8, 0, 1, 10);
        checkOutput("rst rd_en count", rdCntA - r0, 2);

        // A: break has priority over a queued word.
        $display("[TB] A: line break");
        r0 = rdCntA;
        breakA = 1'b1;
        applyStimulus(0, 9'h096);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (txA === 1'b0) cnt = cnt + 1;
        end
        checkOutput("break low clocks", cnt, 50);
        checkOutput("break no rd_en", rdCntA - r0, 0);
        breakA = 1'b0;
        @(negedge clk);
        checkOutput("break release busy", int'(busyA), 1);
        cnt = 0;
        while (txA === 1'b1 && cnt < 200) begin
            cnt = cnt + 1;
            @(negedge clk);
        end
        checkOutput("break release high", cnt, 23);
        captureFrame("after brk 96", 9'h096, 8, 0, 1, 10);
        checkOutput("break rd_en count", rdCntA - r0, 1);

        // B: 9 data bits, even parity, 2 stop bits, latency 3.
        $display("[TB] B: 9E2 latency 3");
        sel = 1;
        r0 = rdCntB;
        baudB = 16'd4;
        applyStimulus(1, 9'h1FE);
        waitStart("B 1FE", 5);
        captureFrame("B 1FE", 9'h1FE, 9, 1, 2, 4);
        baudB = 16'd1;
        applyStimulus(1, 9'h001);
        waitStart("B 001", 5);
        captureFrame("B 001", 9'h001, 9, 1, 2, 2);
        checkOutput("B rd_en count", rdCntB - r0, 2);

        // C: odd parity, latency 2, divisor frozen across a mid-frame change.
        $display("[TB] C: 8O1 latency 2");
        sel = 2;
        r0 = rdCntC;
        baudC = 16'd0;
        applyStimulus(2, 9'h0A5);
        waitStart("C A5", 4);
        captureFrame("C A5", 9'h0A5, 8, 2, 1, 10);
        baudC = 16'd7;
        applyStimulus(2, 9'h0A4);
        waitStart("C A4", 4);
        baudC = 16'd3;
        captureFrame("C A4", 9'h0A4, 8, 2, 1, 7);
        checkOutput("C rd_en count", rdCntC - r0, 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
